// File: rtl/pipelined_addsub_n_if.sv
// Operand/result bundle for pipelined_addsub_n: valid/ready on the operand side and on the result side.
// master drives operands and consumes results; slave is the adder.
interface pipelined_addsub_n_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         c_out;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub_n.sv
// N-bit add/sub with carry pipelined over STAGES chunk adders; flags c_out/ovf/zero, latency STAGES, 1 op/cycle.
// Backpressure stalls the whole pipe as one: in_ready = !out_valid | out_ready, no bubble collapsing.
module pipelined_addsub_n #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pipelined_addsub_n_if.slave bus
);
    localparam int CHUNK = N / STAGES;

    // a/bx carry the not-yet-consumed operand chunks forward, s collects finished chunks.
    typedef struct packed {
        logic         vld;
        logic         cy;
        logic [N-1:0] a;
        logic [N-1:0] bx;
        logic [N-1:0] s;
        logic         ovf;
        logic         zero;
    } stage_t;

    if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_cfg_check
        $error("pipelined_addsub_n: N must be a multiple of STAGES and 1 <= STAGES <= N");
    end

    logic   adv;
    stage_t head;
    stage_t nxt  [STAGES];
    stage_t st_q [STAGES];

    assign adv          = !st_q[STAGES-1].vld || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        head     = '0;
        head.vld = bus.in_valid;
        head.cy  = bus.c_in;
        head.a   = bus.a;
        head.bx  = bus.b ^ {N{bus.sub}};
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         src;
        stage_t         res;
        logic [CHUNK:0] part;

        if (k == 0) begin : g_first
            assign src = head;
        end else begin : g_next
            assign src = st_q[k-1];
        end

        always_comb begin
            part = {1'b0, src.a[k*CHUNK +: CHUNK]}
                 + {1'b0, src.bx[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src.cy};
            res                     = src;
            res.s[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            res.cy                  = part[CHUNK];
            res.ovf                 = 1'b0;
            res.zero                = 1'b0;
            // Flags are only meaningful once the top chunk is done; carry into the MSB is a^bx^s there.
            if (k == STAGES-1) begin
                res.ovf  = part[CHUNK] ^ src.a[N-1] ^ src.bx[N-1] ^ part[CHUNK-1];
                res.zero = (res.s == '0);
            end
        end

        assign nxt[k] = res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= nxt[k];
            end
        end
    end

    assign bus.out_valid = st_q[STAGES-1].vld;
    assign bus.s         = st_q[STAGES-1].s;
    assign bus.c_out     = st_q[STAGES-1].cy;
    assign bus.ovf       = st_q[STAGES-1].ovf;
    assign bus.zero      = st_q[STAGES-1].zero;
endmodule
